// File: rtl/fetch_sequencer.sv
// Fetch/sequencing stage of the 8-bit RISC core: owns the PC, drives the registered
// program ROM, and resolves HLT/SKZ/JMP locally while issuing all other opcodes.
module fetch_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int OPC_W      = 3,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DOUT,
    input  logic              zero,
    input  logic              exec_done,
    input  logic              resume,
    output logic              instr_valid,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    if (DATA_W != OPC_W + ADDR_W) begin : g_bad_width
        $error("fetch_sequencer: DATA_W must equal OPC_W + ADDR_W");
    end

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [OPC_W-1:0]  OP_HLT    = OPC_W'(0);
    localparam logic [OPC_W-1:0]  OP_SKZ    = OPC_W'(1);
    localparam logic [OPC_W-1:0]  OP_JMP    = OPC_W'(7);
    localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(START_ADDR);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   ir_q;
    logic [ADDR_W-1:0]   pc_inc1;
    logic [ADDR_W-1:0]   pc_inc2;
    logic                is_local;

    assign opcode    = ir_q[DATA_W-1 -: OPC_W];
    assign operand   = ir_q[ADDR_W-1:0];
    assign pc        = pc_q;
    assign MEM_ADDR  = pc_q;
    assign halted    = (state_q == S_HALT);
    assign dbg_state = state_q;

    // Both increments wrap modulo 2^ADDR_W by truncation.
    assign pc_inc1  = pc_q + ADDR_W'(1);
    assign pc_inc2  = pc_q + ADDR_W'(2);
    assign is_local = (opcode == OP_HLT) || (opcode == OP_SKZ) || (opcode == OP_JMP);

    // Handshake: instr_valid is high in ISSUE for datapath opcodes; IR and PC hold
    // until the datapath raises exec_done, and that edge retires the instruction.
    assign instr_valid = (state_q == S_ISSUE) && !is_local;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    ir_q    <= MEM_DOUT;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (opcode == OP_HLT) begin
                        state_q <= S_HALT;
                    end else if (opcode == OP_JMP) begin
                        pc_q    <= operand;
                        state_q <= S_FETCH;
                    end else if (opcode == OP_SKZ) begin
                        pc_q    <= zero ? pc_inc2 : pc_inc1;
                        state_q <= S_FETCH;
                    end else if (exec_done) begin
                        pc_q    <= pc_inc1;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        pc_q    <= pc_inc1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a ROM model plus an instruction-level reference that
// walks the program, predicting fetch addresses and issue-cycle outputs.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] mem_addr;
  logic [7:0] mem_dout;
  logic       zero;
  logic       exec_done;
  logic       resume;
  logic       instr_valid;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [4:0] pc;
  logic       halted;
  logic [1:0] dbg_state;

  logic [7:0] rom [32];
  logic [4:0] exp_q[$];
  int         m_pc;
  int         n_checks = 0;
  int         n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  always_ff @(posedge clk) mem_dout <= rom[mem_addr];

  fetch_sequencer #(
    .ADDR_W(5), .DATA_W(8), .OPC_W(3), .START_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .MEM_ADDR(mem_addr), .MEM_DOUT(mem_dout),
    .zero(zero), .exec_done(exec_done), .resume(resume),
    .instr_valid(instr_valid), .opcode(opcode), .operand(operand),
    .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench just after a negedge with reset released: the DUT is in FETCH.
  task automatic do_reset();
    reset = 1'b1; zero = 1'b0; exec_done = 1'b0; resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    m_pc = 0;
    exp_q.delete();
    exp_q.push_back(5'd0);
  endtask

  // Executes one instruction from the reference PC; called at the FETCH negedge.
  task automatic run_instr(input bit zero_v, input int stall, input int hold);
    logic [7:0] inst;
    int         opc, opr;
    inst = rom[m_pc];
    opc  = int'(inst[7:5]);
    opr  = int'(inst[4:0]);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      check("fetch_addr", mem_addr, exp_q.pop_front());
    end
    check("fetch_valid", instr_valid, 0);
    check("fetch_halted", halted, 0);
    exec_done = 1'($urandom); resume = 1'($urandom);
    @(negedge clk);
    check("load_valid", instr_valid, 0);
    check("load_pc", pc, m_pc);
    exec_done = 1'($urandom); resume = 1'($urandom);
    @(negedge clk);
    case (opc)
      0: begin
        check("hlt_valid", instr_valid, 0);
        exec_done = 1'($urandom); resume = 1'b0;
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
          check("halt_flag", halted, 1);
          check("halt_pc", pc, m_pc);
          check("halt_valid", instr_valid, 0);
          exec_done = 1'($urandom);
          @(negedge clk);
        end
        check("halt_flag_last", halted, 1);
        exec_done = 1'b0; resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        m_pc = (m_pc + 1) % 32;
      end
      1: begin
        check("skz_valid", instr_valid, 0);
        zero = zero_v; exec_done = 1'($urandom);
        @(negedge clk);
        zero = 1'($urandom);
        m_pc = (m_pc + (zero_v ? 2 : 1)) % 32;
      end
      7: begin
        check("jmp_valid", instr_valid, 0);
        exec_done = 1'($urandom);
        @(negedge clk);
        m_pc = opr;
      end
      default: begin
        for (int i = 0; i <= stall; i++) begin
          check("iss_valid", instr_valid, 1);
          check("iss_opcode", opcode, opc);
          check("iss_operand", operand, opr);
          check("iss_pc", pc, m_pc);
          exec_done = (i == stall);
          @(negedge clk);
        end
        exec_done = 1'b0;
        m_pc = (m_pc + 1) % 32;
      end
    endcase
    exp_q.push_back(5'(m_pc));
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; exec_done = 1'b0; resume = 1'b0;
    fill_rom_random();

    // LDA 31 with immediate completion, then the fetch from 1
    rom[0] = 8'hBF;
    do_reset();
    run_instr(0, 0, 0);
    run_instr(0, 0, 1);

    // JMP 5
    rom[0] = 8'hE5;
    do_reset();
    run_instr(0, 0, 0);
    run_instr(0, 0, 1);

    // SKZ at 2 and at 31, both zero values
    for (int z = 0; z < 2; z++) begin
      rom[0] = 8'hE2; rom[2] = 8'h20;
      do_reset();
      run_instr(0, 0, 0);
      run_instr(z[0], 0, 0);
      run_instr(0, 0, 1);
      rom[0] = 8'hFF; rom[31] = 8'h20;
      do_reset();
      run_instr(0, 0, 0);
      run_instr(z[0], 0, 0);
      run_instr(0, 0, 1);
    end

    // datapath stall of 4 cycles
    rom[0] = 8'h45;
    do_reset();
    run_instr(0, 4, 0);
    run_instr(0, 0, 1);

    // HLT at 6 held for 10 cycles then resumed
    rom[0] = 8'hE6; rom[6] = 8'h00;
    do_reset();
    run_instr(0, 0, 0);
    run_instr(0, 0, 10);
    run_instr(0, 0, 1);

    // asynchronous reset while a datapath instruction is issued
    rom[0] = 8'hA3;
    do_reset();
    exec_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", instr_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", instr_valid, 0);
    check("async_pc", pc, 0);
    check("async_addr", mem_addr, 0);
    do_reset();
    run_instr(0, 0, 0);
    run_instr(0, 0, 1);

    // random programs
    for (int p = 0; p < 4; p++) begin
      fill_rom_random();
      do_reset();
      for (int n = 0; n < 60; n++) begin
        run_instr(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
